// File: rtl/irq_pkg.sv
// Shared constants for the interrupt collector: register offsets
// (Addr[4:2]), source count limit and PRIO register field layout.
package irq_pkg;

    localparam int MAX_SRC = 16;

    localparam logic [2:0] IRQ_REG_MASK = 3'd0;
    localparam logic [2:0] IRQ_REG_MODE = 3'd1;
    localparam logic [2:0] IRQ_REG_PEND = 3'd2;
    localparam logic [2:0] IRQ_REG_RAW  = 3'd3;
    localparam logic [2:0] IRQ_REG_PRIO = 3'd4;

    localparam int PRIO_VALID_BIT = 31;
    localparam int PRIO_IDX_LSB   = 0;
    localparam int PRIO_IDX_W     = 5;

endpackage

// File: rtl/irq_collector_if.sv
// SystemBridge word-device bus: Addr (word address), WE, Din, Dout.
// master drives the request side, slave (the device) drives Dout.
interface irq_collector_if;

    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser chain, one-cycle-delayed copy and rising pulse.
// Ports: clk, reset (async low), src_i raw, s_o synced, rise_o = s & ~s_d.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic src_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic                   s_dly_q;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], src_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
            s_dly_q <= 1'b0;
        end else begin
            chain_q <= chain_d;
            s_dly_q <= chain_q[SYNC_STAGES-1];
        end
    end

    assign s_o    = chain_q[SYNC_STAGES-1];
    assign rise_o = chain_q[SYNC_STAGES-1] & ~s_dly_q;

endmodule

// File: rtl/irq_collector.sv
// Interrupt front end: sync, level/edge pending, mask, registered irq_out.
// Ports: clk, reset (async low), src, bus (slave), irq_out.
// Optional IRQ_PRIO_EN adds a lowest-index priority encoder on PRIO.
module irq_collector
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    irq_collector_if.slave     bus,
    output logic [NUM_SRC-1:0] irq_out
);

    logic [NUM_SRC-1:0] raw;
    logic [NUM_SRC-1:0] rise;

    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] irq_q,  irq_d;

    logic [NUM_SRC-1:0] din;
    logic [NUM_SRC-1:0] chg;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] pend_v;
    logic [NUM_SRC-1:0] act;
    logic [2:0]         sel;
    logic               wr_mask, wr_mode, wr_pend;
    logic [31:0]        prio;
    logic               unused_bits;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .reset  (reset),
            .src_i  (src[i]),
            .s_o    (raw[i]),
            .rise_o (rise[i])
        );
    end

    assign sel     = bus.Addr[4:2];
    assign din     = bus.Din[NUM_SRC-1:0];
    assign wr_mask = bus.WE && (sel == IRQ_REG_MASK);
    assign wr_mode = bus.WE && (sel == IRQ_REG_MODE);
    assign wr_pend = bus.WE && (sel == IRQ_REG_PEND);

    assign unused_bits = ^{bus.Addr[31:5], bus.Din[31:NUM_SRC]};

    // Level sources read the synced line; edge sources read the latch.
    assign pend_v = (mode_q & pend_q) | (~mode_q & raw);
    assign act    = pend_v & mask_q;

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        chg    = '0;
        w1c    = '0;
        if (wr_mask) mask_d = din;
        if (wr_mode) begin
            mode_d = din;
            chg    = mode_q ^ din;
        end
        if (wr_pend) w1c = din;
        // A mode flip discards the latch; otherwise a new edge beats W1C.
        set    = rise & mode_q & ~chg;
        pend_d = (pend_q & ~w1c & ~chg) | set;
        irq_d  = act;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
            irq_q  <= '0;
        end else begin
            mask_q <= mask_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_out = irq_q;

`ifdef IRQ_PRIO_EN
    logic [PRIO_IDX_W-1:0] idx;
    logic                  vld;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        idx  = '0;
        vld  = |act;
        prio = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) idx = PRIO_IDX_W'(i);
        end
        prio[PRIO_VALID_BIT] = vld;
        prio[PRIO_IDX_LSB +: PRIO_IDX_W] = idx;
    end
`else
    assign prio = 32'h0;
`endif

    always_comb begin
        bus.Dout = 32'h0;
        case (sel)
            IRQ_REG_MASK: bus.Dout = 32'(mask_q);
            IRQ_REG_MODE: bus.Dout = 32'(mode_q);
            IRQ_REG_PEND: bus.Dout = 32'(pend_v);
            IRQ_REG_RAW:  bus.Dout = 32'(raw);
            IRQ_REG_PRIO: bus.Dout = prio;
            default:      bus.Dout = 32'h0;
        endcase
    end

endmodule
